// File: rtl/ariane_pkg.sv
// Shared processor types used by the writeback path.
//   TRANS_ID_BITS : width of a scoreboard entry ID
//   NR_WB_PORTS   : number of scoreboard writeback ports
//   exception_t   : exception record carried alongside every result
//   wb_port_t     : one writeback port as seen by the scoreboard
package ariane_pkg;

  localparam int unsigned NR_SB_ENTRIES = 8;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  // Exception cause codes used by the functional units.
  localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'h0;
  localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'h1;
  localparam logic [63:0] ILLEGAL_INSTR         = 64'h2;
  localparam logic [63:0] BREAKPOINT            = 64'h3;
  localparam logic [63:0] LD_ADDR_MISALIGNED    = 64'h4;
  localparam logic [63:0] LD_ACCESS_FAULT       = 64'h5;
  localparam logic [63:0] ST_ADDR_MISALIGNED    = 64'h6;
  localparam logic [63:0] ST_ACCESS_FAULT       = 64'h7;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               ex;
  } wb_port_t;

endpackage

// File: rtl/rr_multi_select.sv
// Multi-grant round-robin selector.
// Scans requesters starting at rr_i (wrapping at NR_REQ-1 -> 0) and grants
// the first NR_PORTS valid ones. Purely combinational.
//   flush_i     : suppress all grants and force the next pointer to 0
//   valid_i     : per-requester pending flag
//   rr_i        : current round-robin pointer (must be < NR_REQ)
//   grant_o     : per-requester grant
//   sel_valid_o : port p carries a granted requester
//   sel_idx_o   : requester index placed on port p, in scan order
//   rr_next_o   : pointer for the next cycle
module rr_multi_select #(
  parameter int unsigned NR_REQ   = 5,
  parameter int unsigned NR_PORTS = 3,
  parameter int unsigned IDX_W    = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                               flush_i,
  input  logic [NR_REQ-1:0]                  valid_i,
  input  logic [IDX_W-1:0]                   rr_i,
  output logic [NR_REQ-1:0]                  grant_o,
  output logic [NR_PORTS-1:0]                sel_valid_o,
  output logic [NR_PORTS-1:0][IDX_W-1:0]     sel_idx_o,
  output logic [IDX_W-1:0]                   rr_next_o
);

  localparam int unsigned CNT_W = $clog2(NR_PORTS + 1);

  localparam logic [IDX_W:0]   NR_REQ_C   = (IDX_W+1)'(NR_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NR_REQ - 1);
  localparam logic [CNT_W-1:0] NR_PORTS_C = CNT_W'(NR_PORTS);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] cnt;
  logic             any_grant;

  always_comb begin
    grant_o     = '0;
    sel_valid_o = '0;
    sel_idx_o   = '0;
    rr_next_o   = rr_i;
    sum         = '0;
    idx         = '0;
    last_idx    = '0;
    cnt         = '0;
    any_grant   = 1'b0;

    for (int j = 0; j < int'(NR_REQ); j++) begin
      // rr_i < NR_REQ and j < NR_REQ, so a single subtraction wraps the sum.
      sum = {1'b0, rr_i} + (IDX_W+1)'(j);
      if (sum >= NR_REQ_C) begin
        sum = sum - NR_REQ_C;
      end
      idx = sum[IDX_W-1:0];

      if (!flush_i && valid_i[idx] && (cnt < NR_PORTS_C)) begin
        grant_o[idx]     = 1'b1;
        sel_valid_o[cnt] = 1'b1;
        sel_idx_o[cnt]   = idx;
        cnt              = cnt + CNT_W'(1);
        last_idx         = idx;
        any_grant        = 1'b1;
      end
    end

    if (flush_i) begin
      rr_next_o = '0;
    end else if (any_grant) begin
      rr_next_o = (last_idx == LAST_IDX_C) ? '0 : last_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges NR_REQ functional-unit results onto NR_PORTS
// scoreboard writeback ports with round-robin fairness and one cycle of
// registered latency.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   flush_i        : drop all grants this cycle, clear ports, pointer -> 0
//   valid_i        : per-requester result pending
//   trans_id_i     : per-requester scoreboard ID
//   result_i       : per-requester 64-bit result
//   ex_i           : per-requester exception
//   ready_o        : per-requester grant (combinational, same cycle)
//   wb_valid_o     : per-port writeback valid (registered)
//   wb_trans_id_o  : per-port scoreboard ID
//   wb_result_o    : per-port result
//   wb_ex_o        : per-port exception
module wb_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ   = 5,
  parameter int unsigned NR_PORTS = ariane_pkg::NR_WB_PORTS
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic [NR_REQ-1:0]                           valid_i,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]        trans_id_i,
  input  logic [NR_REQ-1:0][63:0]                     result_i,
  input  exception_t [NR_REQ-1:0]                     ex_i,
  output logic [NR_REQ-1:0]                           ready_o,
  output logic [NR_PORTS-1:0]                         wb_valid_o,
  output logic [NR_PORTS-1:0][TRANS_ID_BITS-1:0]      wb_trans_id_o,
  output logic [NR_PORTS-1:0][63:0]                   wb_result_o,
  output exception_t [NR_PORTS-1:0]                   wb_ex_o
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [IDX_W-1:0]              rr_q, rr_d;
  wb_port_t [NR_PORTS-1:0]       wb_q, wb_d;

  logic [NR_REQ-1:0]             grant;
  logic [NR_PORTS-1:0]           sel_valid;
  logic [NR_PORTS-1:0][IDX_W-1:0] sel_idx;

  rr_multi_select #(
    .NR_REQ   (NR_REQ),
    .NR_PORTS (NR_PORTS),
    .IDX_W    (IDX_W)
  ) i_rr_multi_select (
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .rr_i        (rr_q),
    .grant_o     (grant),
    .sel_valid_o (sel_valid),
    .sel_idx_o   (sel_idx),
    .rr_next_o   (rr_d)
  );

  // Grants are hidden while reset is held so no requester retires a result
  // that the registers are about to discard.
  assign ready_o = rst_i ? '0 : grant;

  // Unused ports are driven all-zero rather than holding stale payload.
  always_comb begin
    wb_d = '0;
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      if (sel_valid[p]) begin
        wb_d[p].valid    = 1'b1;
        wb_d[p].trans_id = trans_id_i[sel_idx[p]];
        wb_d[p].result   = result_i[sel_idx[p]];
        wb_d[p].ex       = ex_i[sel_idx[p]];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
      wb_q <= '0;
    end else begin
      rr_q <= rr_d;
      wb_q <= wb_d;
    end
  end

  always_comb begin
    wb_valid_o    = '0;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_o       = '0;
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      wb_valid_o[p]    = wb_q[p].valid;
      wb_trans_id_o[p] = wb_q[p].trans_id;
      wb_result_o[p]   = wb_q[p].result;
      wb_ex_o[p]       = wb_q[p].ex;
    end
  end

  ready_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (ready_o & ~valid_i) == '0);

  flush_blocks_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    flush_i |-> (ready_o == '0));

  grant_count_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    $countones(ready_o) <= NR_PORTS);

endmodule
